tlb_unit: RTL

16-entry fully associative MIPS32 JTLB with dual-page (even/odd) entries. It sits directly beside regs_c0. It executes TLBP/TLBR/TLBWI through a small sequencer. Each result goes back to CP0 on the existing tlbp/tlbp_found/index/tlbr/r_* inputs. It also provides one combinational search port that the fetch/data address translation path uses.

---
 rtl/tlb_unit_if.sv | 61 ++++++
 rtl/tlb_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_unit_if.sv
// rtl/tlb_unit_if.sv - CP0/WB and translation-path bundle for the JTLB
interface tlb_unit_if #(
  parameter int IDXW = 4
);
  // sequencer request/response
  logic            op_valid;
  logic [1:0]      op_type;
  logic            op_ready;
  logic            done;
  logic            refetch;
  // CP0 register snapshot
  logic [31:0]     c0_entryhi;
  logic [31:0]     c0_entrylo0;
  logic [31:0]     c0_entrylo1;
  logic [31:0]     c0_index;
  // probe result
  logic            tlbp;
  logic            tlbp_found;
  logic [IDXW-1:0] index;
  // read result
  logic            tlbr;
  logic [18:0]     r_vpn2;
  logic [7:0]      r_asid;
  logic            r_g;
  logic [19:0]     r_pfn0;
  logic [2:0]      r_c0;
  logic            r_d0;
  logic            r_v0;
  logic [19:0]     r_pfn1;
  logic [2:0]      r_c1;
  logic            r_d1;
  logic            r_v1;
  // combinational search port
  logic [18:0]     s_vpn2;
  logic            s_odd;
  logic [7:0]      s_asid;
  logic            s_found;
  logic [IDXW-1:0] s_index;
  logic [19:0]     s_pfn;
  logic [2:0]      s_c;
  logic            s_d;
  logic            s_v;

  modport master (
    output op_valid, op_type, c0_entryhi, c0_entrylo0, c0_entrylo1, c0_index,
    output s_vpn2, s_odd, s_asid,
    input  op_ready, done, refetch, tlbp, tlbp_found, index,
    input  tlbr, r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0,
    input  r_pfn1, r_c1, r_d1, r_v1,
    input  s_found, s_index, s_pfn, s_c, s_d, s_v
  );

  modport slave (
    input  op_valid, op_type, c0_entryhi, c0_entrylo0, c0_entrylo1, c0_index,
    input  s_vpn2, s_odd, s_asid,
    output op_ready, done, refetch, tlbp, tlbp_found, index,
    output tlbr, r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0,
    output r_pfn1, r_c1, r_d1, r_v1,
    output s_found, s_index, s_pfn, s_c, s_d, s_v
  );
endinterface

// File: rtl/tlb_unit.sv
// rtl/tlb_unit.sv - 16-entry dual-page JTLB with TLBP/TLBR/TLBWI sequencer
module tlb_unit #(
  parameter int TLBNUM = 16,
  parameter int IDXW   = 4
) (
  input logic        clk,
  input logic        rst,
  tlb_unit_if.slave  bus
);

  localparam logic [1:0] OP_TLBP  = 2'b01;
  localparam logic [1:0] OP_TLBR  = 2'b10;
  localparam logic [1:0] OP_TLBWI = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t state_q, state_d;

  // operation latch: CP0 snapshot taken at accept
  logic [1:0]      op_q;
  logic [18:0]     vpn2_q;
  logic [7:0]      asid_q;
  logic [25:0]     lo0_q;
  logic [25:0]     lo1_q;
  logic [IDXW-1:0] idx_q;

  // entry storage
  logic [18:0] e_vpn2_q [TLBNUM];
  logic [7:0]  e_asid_q [TLBNUM];
  logic        e_g_q    [TLBNUM];
  logic [19:0] e_pfn0_q [TLBNUM];
  logic [2:0]  e_c0_q   [TLBNUM];
  logic        e_d0_q   [TLBNUM];
  logic        e_v0_q   [TLBNUM];
  logic [19:0] e_pfn1_q [TLBNUM];
  logic [2:0]  e_c1_q   [TLBNUM];
  logic        e_d1_q   [TLBNUM];
  logic        e_v1_q   [TLBNUM];

  // held result registers
  logic            found_q;
  logic [IDXW-1:0] pidx_q;
  logic [18:0]     r_vpn2_q;
  logic [7:0]      r_asid_q;
  logic            r_g_q;
  logic [19:0]     r_pfn0_q, r_pfn1_q;
  logic [2:0]      r_c0_q, r_c1_q;
  logic            r_d0_q, r_v0_q, r_d1_q, r_v1_q;

  logic            accept;
  logic            p_hit;
  logic [IDXW-1:0] p_idx;
  logic            s_hit;
  logic [IDXW-1:0] s_idx;

  // CP0 bits the TLB does not hold
  logic unused_bits;
  assign unused_bits = ^{bus.c0_entryhi[12:8], bus.c0_entrylo0[31:26],
                         bus.c0_entrylo1[31:26], bus.c0_index[31:IDXW]};

  assign accept = bus.op_valid && (state_q == S_IDLE) && (bus.op_type != 2'b00);

  // sequencer state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // sequencer next state and response pulses
  always_comb begin
    state_d      = state_q;
    bus.op_ready = 1'b0;
    bus.done     = 1'b0;
    bus.tlbp     = 1'b0;
    bus.tlbr     = 1'b0;
    bus.refetch  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        bus.op_ready = 1'b1;
        if (accept) state_d = S_EXEC;
      end
      S_EXEC: state_d = S_RESP;
      S_RESP: begin
        bus.done    = 1'b1;
        bus.tlbp    = (op_q == OP_TLBP);
        bus.tlbr    = (op_q == OP_TLBR);
        bus.refetch = (op_q == OP_TLBWI);
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // snapshot CP0 on accept so later CP0 writes cannot disturb the operation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= 2'b00;
      vpn2_q <= '0;
      asid_q <= '0;
      lo0_q  <= '0;
      lo1_q  <= '0;
      idx_q  <= '0;
    end else if (accept) begin
      op_q   <= bus.op_type;
      vpn2_q <= bus.c0_entryhi[31:13];
      asid_q <= bus.c0_entryhi[7:0];
      lo0_q  <= bus.c0_entrylo0[25:0];
      lo1_q  <= bus.c0_entrylo1[25:0];
      idx_q  <= bus.c0_index[IDXW-1:0];
    end
  end

  // probe match against latched EntryHi; descending scan leaves lowest hit
  always_comb begin
    p_hit = 1'b0;
    p_idx = '0;
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      if (e_vpn2_q[i] == vpn2_q && (e_g_q[i] || e_asid_q[i] == asid_q)) begin
        p_hit = 1'b1;
        p_idx = IDXW'(i);
      end
    end
  end

  // search-port match; descending scan leaves lowest hit
  always_comb begin
    s_hit = 1'b0;
    s_idx = '0;
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      if (e_vpn2_q[i] == bus.s_vpn2 && (e_g_q[i] || e_asid_q[i] == bus.s_asid)) begin
        s_hit = 1'b1;
        s_idx = IDXW'(i);
      end
    end
  end

  // search-port page select: vaddr[12] picks the odd half
  always_comb begin
    bus.s_found = s_hit;
    bus.s_index = s_idx;
    bus.s_pfn   = bus.s_odd ? e_pfn1_q[s_idx] : e_pfn0_q[s_idx];
    bus.s_c     = bus.s_odd ? e_c1_q[s_idx]   : e_c0_q[s_idx];
    bus.s_d     = bus.s_odd ? e_d1_q[s_idx]   : e_d0_q[s_idx];
    bus.s_v     = bus.s_odd ? e_v1_q[s_idx]   : e_v0_q[s_idx];
  end

  // TLBWI commits at the end of EXEC
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TLBNUM; i++) begin
        e_vpn2_q[i] <= '0;
        e_asid_q[i] <= '0;
        e_g_q[i]    <= 1'b0;
        e_pfn0_q[i] <= '0;
        e_c0_q[i]   <= '0;
        e_d0_q[i]   <= 1'b0;
        e_v0_q[i]   <= 1'b0;
        e_pfn1_q[i] <= '0;
        e_c1_q[i]   <= '0;
        e_d1_q[i]   <= 1'b0;
        e_v1_q[i]   <= 1'b0;
      end
    end else if (state_q == S_EXEC && op_q == OP_TLBWI) begin
      e_vpn2_q[idx_q] <= vpn2_q;
      e_asid_q[idx_q] <= asid_q;
      e_g_q[idx_q]    <= lo0_q[0] & lo1_q[0];
      e_pfn0_q[idx_q] <= lo0_q[25:6];
      e_c0_q[idx_q]   <= lo0_q[5:3];
      e_d0_q[idx_q]   <= lo0_q[2];
      e_v0_q[idx_q]   <= lo0_q[1];
      e_pfn1_q[idx_q] <= lo1_q[25:6];
      e_c1_q[idx_q]   <= lo1_q[5:3];
      e_d1_q[idx_q]   <= lo1_q[2];
      e_v1_q[idx_q]   <= lo1_q[1];
    end
  end

  // probe result: found always updates, index only on a hit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      found_q <= 1'b0;
      pidx_q  <= '0;
    end else if (state_q == S_EXEC && op_q == OP_TLBP) begin
      found_q <= p_hit;
      if (p_hit) pidx_q <= p_idx;
    end
  end

  // read result: capture the indexed entry, held until the next TLBR
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vpn2_q <= '0;
      r_asid_q <= '0;
      r_g_q    <= 1'b0;
      r_pfn0_q <= '0;
      r_c0_q   <= '0;
      r_d0_q   <= 1'b0;
      r_v0_q   <= 1'b0;
      r_pfn1_q <= '0;
      r_c1_q   <= '0;
      r_d1_q   <= 1'b0;
      r_v1_q   <= 1'b0;
    end else if (state_q == S_EXEC && op_q == OP_TLBR) begin
      r_vpn2_q <= e_vpn2_q[idx_q];
      r_asid_q <= e_asid_q[idx_q];
      r_g_q    <= e_g_q[idx_q];
      r_pfn0_q <= e_pfn0_q[idx_q];
      r_c0_q   <= e_c0_q[idx_q];
      r_d0_q   <= e_d0_q[idx_q];
      r_v0_q   <= e_v0_q[idx_q];
      r_pfn1_q <= e_pfn1_q[idx_q];
      r_c1_q   <= e_c1_q[idx_q];
      r_d1_q   <= e_d1_q[idx_q];
      r_v1_q   <= e_v1_q[idx_q];
    end
  end

  assign bus.tlbp_found = found_q;
  assign bus.index      = pidx_q;
  assign bus.r_vpn2     = r_vpn2_q;
  assign bus.r_asid     = r_asid_q;
  assign bus.r_g        = r_g_q;
  assign bus.r_pfn0     = r_pfn0_q;
  assign bus.r_c0       = r_c0_q;
  assign bus.r_d0       = r_d0_q;
  assign bus.r_v0       = r_v0_q;
  assign bus.r_pfn1     = r_pfn1_q;
  assign bus.r_c1       = r_c1_q;
  assign bus.r_d1       = r_d1_q;
  assign bus.r_v1       = r_v1_q;

endmodule
